// File: rtl/perip_arbiter_pkg.sv
// Shared definitions for the peripheral-bus arbiter and its round-robin helper.
package perip_arbiter_pkg;

    localparam int          RAM_MASK_WIDTH = 4;
    localparam logic [31:0] ERR_DATA_DEF   = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/perip_arbiter_if.sv
// Split req/addr_ok/data_ok handshake shared by requesters and the peripheral slave.
interface perip_arbiter_if #(
    parameter int MASK_W = perip_arbiter_pkg::RAM_MASK_WIDTH
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [MASK_W-1:0] wem;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;
    logic              err;

    // master issues requests; slave answers them
    modport master (
        output req, we, addr, wdata, wem,
        input  addr_ok, data_ok, rdata, err
    );
    modport slave (
        input  req, we, addr, wdata, wem,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/perip_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant: on a tie the requester that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] |  last_grant);
    assign gnt[1] = req[1] & (~req[0] | ~last_grant);
endmodule

// File: rtl/perip_arbiter.sv
// Two-master to one-slave peripheral-bus arbiter with one outstanding transaction and a response timeout.
module perip_arbiter
    import perip_arbiter_pkg::*;
#(
    parameter int          MASK_W   = RAM_MASK_WIDTH,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input logic            clk,
    input logic            rst_n,
    perip_arbiter_if.slave  m0,
    perip_arbiter_if.slave  m1,
    perip_arbiter_if.master s
);
    state_t            state, state_n;
    logic              owner, owner_n;
    logic              last_grant, last_grant_n;
    logic [7:0]        cnt, cnt_n;
    logic [1:0]        req, gnt;
    logic [1:0]        addr_ok, data_ok, err;
    logic [31:0]       rsp_data;
    logic              s_req, s_we;
    logic [31:0]       s_addr, s_wdata;
    logic [MASK_W-1:0] s_wem;
    logic              unused_s_err;

    assign req          = {m1.req, m0.req};
    assign unused_s_err = s.err;

    rr_arb2 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 8'd0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        s_req        = 1'b0;
        s_we         = 1'b0;
        s_addr       = 32'd0;
        s_wdata      = 32'd0;
        s_wem        = '0;
        addr_ok      = 2'b00;
        data_ok      = 2'b00;
        err          = 2'b00;
        rsp_data     = 32'd0;
        case (state)
            IDLE: begin
                if (|req) begin
                    s_req = 1'b1;
                    if (gnt[1]) begin
                        s_we = m1.we; s_addr = m1.addr; s_wdata = m1.wdata; s_wem = m1.wem;
                    end else begin
                        s_we = m0.we; s_addr = m0.addr; s_wdata = m0.wdata; s_wem = m0.wem;
                    end
                    addr_ok[gnt[1]] = s.addr_ok;
                    if (s.addr_ok) begin
                        state_n      = WAIT;
                        owner_n      = gnt[1];
                        last_grant_n = gnt[1];
                        cnt_n        = 8'd0;
                    end
                end
            end
            WAIT: begin
                // a real response beats a timeout landing in the same cycle
                if (s.data_ok) begin
                    data_ok[owner] = 1'b1;
                    rsp_data       = s.rdata;
                    state_n        = IDLE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    data_ok[owner] = 1'b1;
                    err[owner]     = 1'b1;
                    rsp_data       = ERR_DATA;
                    state_n        = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign s.req      = s_req;
    assign s.we       = s_we;
    assign s.addr     = s_addr;
    assign s.wdata    = s_wdata;
    assign s.wem      = s_wem;

    assign m0.addr_ok = addr_ok[0];
    assign m0.data_ok = data_ok[0];
    assign m0.err     = err[0];
    assign m0.rdata   = data_ok[0] ? rsp_data : 32'd0;
    assign m1.addr_ok = addr_ok[1];
    assign m1.data_ok = data_ok[1];
    assign m1.err     = err[1];
    assign m1.rdata   = data_ok[1] ? rsp_data : 32'd0;
endmodule

// File: tb/tb_perip_arbiter.sv
// Directed bench for perip_arbiter: grant order, handshake timing, timeout and reset behaviour.
module tb_perip_arbiter;
    import perip_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    perip_arbiter_if #(.MASK_W(4)) m0_if ();
    perip_arbiter_if #(.MASK_W(4)) m1_if ();
    perip_arbiter_if #(.MASK_W(4)) s_if ();

    perip_arbiter #(.MASK_W(4), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if.slave),
        .m1    (m1_if.slave),
        .s     (s_if.master)
    );

    always #5 clk = ~clk;

    // every DUT output concatenated, for "all outputs zero" checks
    function automatic logic [139:0] all_out();
        return {s_if.req, s_if.we, s_if.addr, s_if.wdata, s_if.wem,
                m0_if.addr_ok, m0_if.data_ok, m0_if.rdata, m0_if.err,
                m1_if.addr_ok, m1_if.data_ok, m1_if.rdata, m1_if.err};
    endfunction

    // advance to the next negedge, where inputs change; checks follow #1 later
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_if.req = 0; m0_if.we = 0; m0_if.addr = 0; m0_if.wdata = 0; m0_if.wem = 0;
        m1_if.req = 0; m1_if.we = 0; m1_if.addr = 0; m1_if.wdata = 0; m1_if.wem = 0;
        s_if.addr_ok = 0; s_if.data_ok = 0; s_if.rdata = 0; s_if.err = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        step(); step(); #1;
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all_out()); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %b exp 0", dut.state); end
        step(); rst_n = 1; #1;
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL idle_outputs got %h exp 0", all_out()); end
    endtask

    task automatic test_back_to_back();
        logic w;
        step();
        m0_if.req = 1; m0_if.we = 1; m0_if.addr = 32'h0; m0_if.wdata = 32'h5; m0_if.wem = 4'hF;
        m1_if.req = 1; m1_if.we = 0; m1_if.addr = 32'h4; m1_if.wdata = 32'h0; m1_if.wem = 4'h0;
        s_if.addr_ok = 1;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) step();
            w = ((i / 2) % 2) == 1;
            s_if.data_ok = (i % 2 == 1);
            s_if.rdata = 32'h100 + i;
            #1;
            if (i % 2 == 0) begin
                checks++; if (s_if.req !== 1'b1) begin errors++; $display("FAIL b2b_sreq[%0d] got %b exp 1", i, s_if.req); end
                checks++; if ({m1_if.addr_ok, m0_if.addr_ok} !== (w ? 2'b10 : 2'b01))
                    begin errors++; $display("FAIL b2b_grant[%0d] got %b exp %b", i, {m1_if.addr_ok, m0_if.addr_ok}, (w ? 2'b10 : 2'b01)); end
                checks++; if ({s_if.we, s_if.addr, s_if.wdata, s_if.wem} !== (w ? {1'b0, 32'h4, 32'h0, 4'h0} : {1'b1, 32'h0, 32'h5, 4'hF}))
                    begin errors++; $display("FAIL b2b_fwd[%0d] got %h/%h/%h", i, s_if.addr, s_if.wdata, s_if.wem); end
            end else begin
                checks++; if ({s_if.req, m1_if.addr_ok, m0_if.addr_ok} !== 3'b000)
                    begin errors++; $display("FAIL b2b_wait_quiet[%0d] got %b exp 000", i, {s_if.req, m1_if.addr_ok, m0_if.addr_ok}); end
                checks++; if ({m1_if.data_ok, m0_if.data_ok} !== (w ? 2'b10 : 2'b01))
                    begin errors++; $display("FAIL b2b_data_ok[%0d] got %b exp %b", i, {m1_if.data_ok, m0_if.data_ok}, (w ? 2'b10 : 2'b01)); end
                checks++; if ((w ? m1_if.rdata : m0_if.rdata) !== 32'h100 + i)
                    begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, (w ? m1_if.rdata : m0_if.rdata), 32'h100 + i); end
            end
        end
        step(); idle_inputs(); #1;
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL b2b_end got %h exp 0", all_out()); end
    endtask

    task automatic test_single_read();
        step();
        m0_if.req = 1; m0_if.we = 0; m0_if.addr = 32'h4; s_if.addr_ok = 1; #1;
        checks++; if ({s_if.req, s_if.we, s_if.addr} !== {1'b1, 1'b0, 32'h4})
            begin errors++; $display("FAIL rd_fwd got %b/%b/%h exp 1/0/4", s_if.req, s_if.we, s_if.addr); end
        checks++; if ({m1_if.addr_ok, m0_if.addr_ok} !== 2'b01)
            begin errors++; $display("FAIL rd_addr_ok got %b exp 01", {m1_if.addr_ok, m0_if.addr_ok}); end
        step();
        m0_if.req = 0; s_if.addr_ok = 0; s_if.data_ok = 1; s_if.rdata = 32'h3; #1;
        checks++; if ({m0_if.data_ok, m0_if.err, m0_if.rdata} !== {1'b1, 1'b0, 32'h3})
            begin errors++; $display("FAIL rd_rsp got %b/%b/%h exp 1/0/3", m0_if.data_ok, m0_if.err, m0_if.rdata); end
        checks++; if ({m1_if.addr_ok, m1_if.data_ok, m1_if.rdata, m1_if.err, s_if.req} !== '0)
            begin errors++; $display("FAIL rd_m1_quiet got %b/%h exp 0", m1_if.data_ok, m1_if.rdata); end
        step(); idle_inputs(); #1;
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL rd_end got %h exp 0", all_out()); end
    endtask

    task automatic test_addr_stall();
        step();
        m1_if.req = 1; m1_if.we = 1; m1_if.addr = 32'h8; m1_if.wdata = 32'hA5; m1_if.wem = 4'h3;
        s_if.addr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            #1;
            checks++; if ({s_if.req, m1_if.addr_ok, m0_if.addr_ok} !== 3'b100)
                begin errors++; $display("FAIL stall[%0d] got %b exp 100", i, {s_if.req, m1_if.addr_ok, m0_if.addr_ok}); end
            checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL stall_state[%0d] got %b exp 0", i, dut.state); end
        end
        step(); s_if.addr_ok = 1; #1;
        checks++; if ({m1_if.addr_ok, s_if.addr, s_if.wem} !== {1'b1, 32'h8, 4'h3})
            begin errors++; $display("FAIL stall_accept got %b/%h/%h exp 1/8/3", m1_if.addr_ok, s_if.addr, s_if.wem); end
        step(); m1_if.req = 0; s_if.addr_ok = 0; s_if.data_ok = 1; s_if.rdata = 32'h77; #1;
        checks++; if (dut.state !== WAIT) begin errors++; $display("FAIL stall_wait got %b exp 1", dut.state); end
        checks++; if ({s_if.req, m1_if.data_ok, m1_if.rdata} !== {1'b0, 1'b1, 32'h77})
            begin errors++; $display("FAIL stall_rsp got %b/%b/%h exp 0/1/77", s_if.req, m1_if.data_ok, m1_if.rdata); end
        step(); idle_inputs();
    endtask

    task automatic test_timeout();
        step();
        m0_if.req = 1; m0_if.we = 1; m0_if.addr = 32'hC; s_if.addr_ok = 1; #1;
        checks++; if (m0_if.addr_ok !== 1'b1) begin errors++; $display("FAIL to_accept got %b exp 1", m0_if.addr_ok); end
        step(); idle_inputs();
        for (int k = 1; k <= 16; k++) begin
            if (k != 1) step();
            #1;
            if (k < 16) begin
                checks++; if ({m0_if.data_ok, m1_if.data_ok, s_if.req} !== 3'b000)
                    begin errors++; $display("FAIL to_early[%0d] got %b exp 000", k, {m0_if.data_ok, m1_if.data_ok, s_if.req}); end
            end else begin
                checks++; if ({m0_if.data_ok, m0_if.err, m0_if.rdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF})
                    begin errors++; $display("FAIL to_fire got %b/%b/%h exp 1/1/deadbeef", m0_if.data_ok, m0_if.err, m0_if.rdata); end
                checks++; if ({m1_if.data_ok, m1_if.err} !== 2'b00)
                    begin errors++; $display("FAIL to_m1_quiet got %b exp 00", {m1_if.data_ok, m1_if.err}); end
            end
        end
        step(); s_if.data_ok = 1; s_if.rdata = 32'h99; #1;
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL to_stray got %h exp 0", all_out()); end
        step(); idle_inputs();
    endtask

    task automatic test_timeout_race();
        step();
        m1_if.req = 1; m1_if.addr = 32'h10; s_if.addr_ok = 1; #1;
        checks++; if (m1_if.addr_ok !== 1'b1) begin errors++; $display("FAIL race_accept got %b exp 1", m1_if.addr_ok); end
        step(); idle_inputs();
        for (int k = 2; k <= 16; k++) step();
        s_if.data_ok = 1; s_if.rdata = 32'h1234; #1;
        checks++; if ({m1_if.data_ok, m1_if.err, m1_if.rdata} !== {1'b1, 1'b0, 32'h1234})
            begin errors++; $display("FAIL race_rsp got %b/%b/%h exp 1/0/1234", m1_if.data_ok, m1_if.err, m1_if.rdata); end
        step(); idle_inputs(); #1;
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL race_end got %h exp 0", all_out()); end
    endtask

    task automatic test_reset_mid();
        step();
        m0_if.req = 1; m0_if.addr = 32'h20; s_if.addr_ok = 1; #1;
        checks++; if (m0_if.addr_ok !== 1'b1) begin errors++; $display("FAIL rm_accept got %b exp 1", m0_if.addr_ok); end
        step(); idle_inputs(); rst_n = 0;
        step(); s_if.data_ok = 1; s_if.rdata = 32'h55; #1;
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL rm_outputs got %h exp 0", all_out()); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rm_state got %b exp 0", dut.state); end
        step(); idle_inputs(); rst_n = 1;
        step(); m0_if.req = 1; m1_if.req = 1; s_if.addr_ok = 1; #1;
        checks++; if ({m1_if.addr_ok, m0_if.addr_ok} !== 2'b01)
            begin errors++; $display("FAIL rm_tie got %b exp 01", {m1_if.addr_ok, m0_if.addr_ok}); end
        step(); idle_inputs(); s_if.data_ok = 1; #1;
        checks++; if ({m1_if.data_ok, m0_if.data_ok} !== 2'b01)
            begin errors++; $display("FAIL rm_rsp got %b exp 01", {m1_if.data_ok, m0_if.data_ok}); end
        step(); idle_inputs();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_read();
        test_addr_stall();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
